// File: rtl/pipe_ctrl_pkg.sv
// Shared action encoding and field widths for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for the stall/flush performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: drives stage-register enables/flushes and PC control,
// plus perf counters and a sticky data-memory timeout flag.
//
// state | meaning
// ------+----------------------------------------------------------
// RUN      | normal advance, pc+4
// LU_STALL | hold PC and IF/ID, insert bubble into ID/EX
// REDIRECT | load branch/jump target, flush IF/ID, ID/EX, EX/MEM
// MEM_WAIT | freeze everything upstream of MEM, bubble into MEM/WB
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_BITS = 16,
    parameter int TIMEOUT  = 64,
    parameter int TO_BITS  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs1_i,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs2_i,
    input  logic                  IF_ID_use_rs1_i,
    input  logic                  IF_ID_use_rs2_i,
    input  logic                  ID_EX_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ID_EX_write_register_i,
    input  logic                  EX_MEM_branch_i,
    input  logic                  EX_MEM_zero_i,
    input  logic                  EX_MEM_jalr_i,
    input  logic                  EX_MEM_mem_read_i,
    input  logic                  EX_MEM_mem_write_i,
    input  logic                  dmem_ready_i,
    output logic                  pc_write_o,
    output logic                  pc_src_o,
    output logic                  IF_ID_write_o,
    output logic                  IF_ID_flush_o,
    output logic                  ID_EX_write_o,
    output logic                  ID_EX_flush_o,
    output logic                  EX_MEM_write_o,
    output logic                  EX_MEM_flush_o,
    output logic                  MEM_WB_flush_o,
    output logic [1:0]            state_o,
    output logic [CNT_BITS-1:0]   stall_count_o,
    output logic [CNT_BITS-1:0]   flush_count_o,
    output logic                  err_timeout_o
);

    logic               mem_busy;
    logic               redirect;
    logic               load_use;
    logic [1:0]         action_d;
    logic [1:0]         state_q;
    logic [TO_BITS-1:0] wait_q;
    logic               err_q;

    assign mem_busy = (EX_MEM_mem_read_i | EX_MEM_mem_write_i) & ~dmem_ready_i;
    assign redirect = (EX_MEM_branch_i & EX_MEM_zero_i) | EX_MEM_jalr_i;
    assign load_use = ID_EX_mem_read_i && (ID_EX_write_register_i != '0) &&
                      ((IF_ID_use_rs1_i && (IF_ID_rs1_i == ID_EX_write_register_i)) ||
                       (IF_ID_use_rs2_i && (IF_ID_rs2_i == ID_EX_write_register_i)));

    // Priority order: a frozen EX/MEM defers any redirect; a redirect kills the stalled ID op.
    always_comb begin
        if (mem_busy)      action_d = ST_MEM_WAIT;
        else if (redirect) action_d = ST_REDIRECT;
        else if (load_use) action_d = ST_LU_STALL;
        else               action_d = ST_RUN;
    end

    always_comb begin
        pc_write_o     = 1'b1;
        pc_src_o       = 1'b0;
        IF_ID_write_o  = 1'b1;
        IF_ID_flush_o  = 1'b0;
        ID_EX_write_o  = 1'b1;
        ID_EX_flush_o  = 1'b0;
        EX_MEM_write_o = 1'b1;
        EX_MEM_flush_o = 1'b0;
        MEM_WB_flush_o = 1'b0;
        case (action_d)
            ST_MEM_WAIT: begin
                pc_write_o     = 1'b0;
                IF_ID_write_o  = 1'b0;
                ID_EX_write_o  = 1'b0;
                EX_MEM_write_o = 1'b0;
                MEM_WB_flush_o = 1'b1;
            end
            ST_REDIRECT: begin
                pc_src_o       = 1'b1;
                IF_ID_flush_o  = 1'b1;
                ID_EX_flush_o  = 1'b1;
                EX_MEM_flush_o = 1'b1;
            end
            ST_LU_STALL: begin
                pc_write_o     = 1'b0;
                IF_ID_write_o  = 1'b0;
                ID_EX_flush_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // wait_q parks at TIMEOUT-1 so it never wraps during an endless wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= action_d;
            if (action_d == ST_MEM_WAIT) begin
                if (wait_q == TO_BITS'(TIMEOUT - 1)) begin
                    err_q <= 1'b1;
                end else begin
                    wait_q <= wait_q + 1'b1;
                end
            end else begin
                wait_q <= '0;
            end
        end
    end

    sat_counter #(.W(CNT_BITS)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   ((action_d == ST_LU_STALL) || (action_d == ST_MEM_WAIT)),
        .q     (stall_count_o)
    );

    sat_counter #(.W(CNT_BITS)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (action_d == ST_REDIRECT),
        .q     (flush_count_o)
    );

    assign state_o       = state_q;
    assign err_timeout_o = err_q;

endmodule
